// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in parallel-out deserializer.
//   - sipo_state_e / ST_* : receive FSM state encoding
//   - SIPO_WIDTH_DEFAULT   : default word width, common with the piso transmitter
//   - cnt_width()          : bit-counter width able to hold 0..WIDTH+1
// Optional feature macro: SIPO_PARITY_EN (appends an even-parity bit to each frame).
package sipo_pkg;

    localparam int unsigned SIPO_WIDTH_DEFAULT = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_e;

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_SHIFT = SHIFT;

    // Counter must reach WIDTH+1 when the parity bit is part of the frame.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register, bit counter and parity accumulator of the deserializer.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   bit_in         : serial data bit
//   bit_en         : bit_in is accepted into the current frame this cycle
//   first          : accepted bit starts a fresh frame (partial word discarded)
//   word_c         : word as it will look after this cycle's shift (combinational)
//   word_done_c    : this cycle's bit is the last bit of the frame (combinational)
//   parity_ok_c    : frame parity is even at completion; constant 1 without parity
// Optional feature macro: SIPO_PARITY_EN.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = SIPO_WIDTH_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bit_in,
    input  logic             bit_en,
    input  logic             first,
    output logic [WIDTH-1:0] word_c,
    output logic             word_done_c,
    output logic             parity_ok_c
);

    localparam int unsigned CW = cnt_width(WIDTH);
`ifdef SIPO_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif

    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] base_c;
    logic [CW-1:0]    cnt_base_c;
    logic             data_bit_c;
`ifdef SIPO_PARITY_EN
    logic             par_acc;
    logic             par_next_c;
`endif

    // Insert one bit at the end selected by MSB_FIRST.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s, input logic b);
        logic [WIDTH-1:0] r;
        if (MSB_FIRST) begin
            r = {s[WIDTH-2:0], b};
        end else begin
            r = {b, s[WIDTH-1:1]};
        end
        return r;
    endfunction

    // A start bit shifts into an empty register with the count restarted.
    always_comb begin
        base_c      = first ? '0 : sreg;
        cnt_base_c  = first ? '0 : cnt;
        data_bit_c  = 1'b1;
`ifdef SIPO_PARITY_EN
        data_bit_c  = (cnt_base_c < CW'(WIDTH));
        par_next_c  = first ? bit_in : (par_acc ^ bit_in);
        parity_ok_c = ~par_next_c;
`else
        parity_ok_c = 1'b1;
`endif
        word_c      = (bit_en && data_bit_c) ? shift_in(base_c, bit_in) : sreg;
        word_done_c = bit_en && (cnt_base_c == CW'(FRAME_LEN - 1));
    end

    // Frame state; cleared on completion so the next frame starts clean.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg    <= '0;
            cnt     <= '0;
`ifdef SIPO_PARITY_EN
            par_acc <= 1'b0;
`endif
        end else if (bit_en) begin
            if (word_done_c) begin
                sreg    <= '0;
                cnt     <= '0;
`ifdef SIPO_PARITY_EN
                par_acc <= 1'b0;
`endif
            end else begin
                sreg    <= word_c;
                cnt     <= cnt_base_c + CW'(1);
`ifdef SIPO_PARITY_EN
                par_acc <= par_next_c;
`endif
            end
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer with valid/ready output port.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   serial_in     : serial data bit, qualified by in_valid
//   in_valid      : serial_in carries a bit this cycle
//   in_start      : with in_valid, the bit is the first bit of a frame
//   parallel_out  : assembled word, stable while out_valid && !out_ready
//   out_valid     : parallel_out holds an unconsumed word
//   out_ready     : consumer takes the word when out_valid && out_ready
//   overrun       : sticky, a completed word was dropped (cleared by overrun_clr)
//   overrun_clr   : synchronous clear of overrun; a same-cycle overrun wins
//   frame_err     : one-cycle pulse when a start bit restarts a partial frame
//   parity_err    : (SIPO_PARITY_EN only) one-cycle pulse, word discarded
// Optional feature macro: SIPO_PARITY_EN.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = SIPO_WIDTH_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             serial_in,
    input  logic             in_valid,
    input  logic             in_start,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             frame_err
`ifdef SIPO_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [WIDTH-1:0] pout_nxt;
    logic             ov_nxt;
    logic             or_nxt;
    logic             fe_nxt;
    logic             first_c;
    logic             bit_en_c;
    logic [WIDTH-1:0] word_c;
    logic             word_done_c;
    logic             parity_ok_c;
    logic             word_ok_c;
`ifdef SIPO_PARITY_EN
    logic             pe_nxt;
`endif

    // Non-start bits outside a frame are dropped silently.
    assign first_c  = in_valid & in_start;
    assign bit_en_c = in_valid & (in_start | (state == ST_SHIFT));

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk         (clk),
        .reset_n     (reset_n),
        .bit_in      (serial_in),
        .bit_en      (bit_en_c),
        .first       (first_c),
        .word_c      (word_c),
        .word_done_c (word_done_c),
        .parity_ok_c (parity_ok_c)
    );

    assign word_ok_c = word_done_c & parity_ok_c;

    // Next state, output register, handshake and flags.
    always_comb begin
        state_nxt = state;
        pout_nxt  = parallel_out;
        ov_nxt    = out_valid;
        or_nxt    = overrun;
        fe_nxt    = 1'b0;
`ifdef SIPO_PARITY_EN
        pe_nxt    = word_done_c & ~parity_ok_c;
`endif

        case (state)
            ST_IDLE: begin
                if (first_c) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (first_c) begin
                    fe_nxt = 1'b1;
                end
                if (word_done_c) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A word completing on the consume edge replaces the old one directly.
        if (word_ok_c && (!out_valid || out_ready)) begin
            pout_nxt = word_c;
            ov_nxt   = 1'b1;
        end else if (out_valid && out_ready) begin
            ov_nxt = 1'b0;
        end

        if (word_ok_c && out_valid && !out_ready) begin
            or_nxt = 1'b1;
        end else if (overrun_clr) begin
            or_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            parallel_out <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
            frame_err    <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err   <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            parallel_out <= pout_nxt;
            out_valid    <= ov_nxt;
            overrun      <= or_nxt;
            frame_err    <= fe_nxt;
`ifdef SIPO_PARITY_EN
            parity_err   <= pe_nxt;
`endif
        end
    end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
Serial-in parallel-out deserializer; the receive end paired with the team's piso shift register. Collects WIDTH framed serial bits into a parallel word and presents it on a valid/ready output port. Flags framing errors and overruns. Sits downstream of any piso-driven serial link.

Parameters:
WIDTH, 3, bits per word (>=2)
MSB_FIRST, 1, 1 = first received bit lands in parallel_out[WIDTH-1]; 0 = first bit lands in parallel_out[0]

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
serial_in  input  1  serial data bit
in_valid  input  1  serial_in carries a bit this cycle
in_start  input  1  qualified by in_valid: this bit is the first bit of a frame
parallel_out  output  WIDTH  assembled word, stable while out_valid=1
out_valid  output  1  parallel_out holds an unconsumed word
out_ready  input  1  consumer accepts the word when out_valid && out_ready
overrun  output  1  sticky: a completed word was dropped
overrun_clr  input  1  synchronous clear of overrun
frame_err  output  1  one-cycle pulse: frame restarted or abandoned mid-word

Behaviour:
- Reset (reset_n=0, async): state=IDLE, bit count=0, shift reg=0, parallel_out=0, out_valid=0, overrun=0, frame_err=0.
- FSM states: IDLE, SHIFT.
- IDLE:
  - in_valid && in_start: shift in the bit, count=1, go to SHIFT.
  - in_valid without in_start: bit ignored, no flag.
- SHIFT:
  - in_valid && !in_start: shift in the bit, count++.
  - in_valid && in_start: discard the partial word, pulse frame_err, restart with this bit, count=1.
  - in_valid low: hold state and count. No timeout.
- Completion: the edge that samples bit WIDTH completes the word. FSM returns to IDLE and count resets to 0.
  - Output register free (out_valid=0, or out_valid && out_ready that same cycle): load parallel_out, out_valid=1 in the following cycle. Latency is one clock after the last bit is sampled.
  - Output register occupied and out_ready=0: drop the new word, keep the old one, set overrun.
- Shift order:
  - MSB_FIRST=1: shift left, new bit enters [0].
  - MSB_FIRST=0: shift right, new bit enters [WIDTH-1].
- Handshake: out_valid falls on the edge where out_ready=1, unless a word completes on the same edge, in which case out_valid stays 1 with the new word. parallel_out never changes while out_valid=1 && out_ready=0.
- overrun_clr and an overrun event on the same edge: overrun stays set (set wins).
- Back-to-back frames: in_start may arrive the cycle after completion. No dead cycle is required.
- reset_n asserted mid-frame: all state is discarded immediately. The first valid bit after release must carry in_start.

Optional Feature:
SIPO_PARITY_EN
- Defined: each frame is WIDTH+1 bits; the last bit is even parity over the data bits. Adds output port parity_err (one-cycle pulse). On parity mismatch the word is discarded: no out_valid, no overrun, parity_err=1 for one cycle.
- Undefined: frames are WIDTH bits, no parity_err port, no parity logic.

Decomposition:
- Package sipo_pkg: state enum (IDLE, SHIFT), count-width function ($clog2(WIDTH+2)), default WIDTH constant shared with the piso.
- Sub-module sipo_shift_core: shift register, bit counter and parity accumulator. It reports word_done and parity_ok.
- Top level: FSM, output register, handshake, and error/overrun flags.

Test Plan:
- WIDTH=3, MSB_FIRST=1: bits 1(start),0,1 with in_valid each cycle, out_ready=1 -> parallel_out=3'b101, out_valid high exactly one cycle, one clock after the third bit.
- MSB_FIRST=0: bits 1(start),0,0 -> parallel_out=3'b001. Then 0(start),0,1 -> 3'b100.
- in_valid gaps: bits 1(start), idle 3 cycles, 1, idle, 0 -> 3'b110, no frame_err.
- Restart: 1(start),1 then 0(start),1,1 -> frame_err pulse on the second start, parallel_out=3'b011.
- Overrun: out_ready=0, two complete frames 3'b101 then 3'b010 -> parallel_out stays 3'b101, overrun=1. overrun_clr -> overrun=0. out_ready=1 -> out_valid drops.
- Async reset mid-frame after 2 bits -> all outputs 0 immediately. The following non-start bits are ignored. A subsequent start frame 1,1,1 -> 3'b111.
